ptmch_trg_seq: RTL and testbench

Two-stage trigger sequencer placed after the SPI instruction-match trigger decoder. It consumes the five 15-cycle trigger pulses on TRG_PLS and, once armed, waits for a stage-0 event. It then optionally waits for a stage-1 event within a cycle window and emits a single capture pulse toward the scope/logic-analyzer header. It also maintains fire and timeout statistics for the status register block.

---
 rtl/ptmch_pkg.sv | 19 +
 rtl/ptmch_sat_cnt.sv | 21 ++
 rtl/ptmch_trg_seq.sv | 200 ++++++++++++++++++++
 tb/tb_ptmch_trg_seq.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptmch_pkg.sv
// Shared types and trigger-bit indices for the SPI instruction-match trigger path.
// The decoder uses the same bit numbering on TRG_PLS.
package ptmch_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT0,
        S_WAIT1,
        S_FIRE,
        S_HOLD
    } t_seq_state;

    localparam int TRG_PGM_EXEC  = 0;
    localparam int TRG_RD_STAT   = 1;
    localparam int TRG_BLK_ERASE = 2;
    localparam int TRG_PAGE_READ = 3;
    localparam int TRG_WR_STAT   = 4;

endpackage

// File: rtl/ptmch_sat_cnt.sv
// Up-counter with synchronous clear and enable.
// It stops at all-ones instead of wrapping.
module ptmch_sat_cnt #(
    parameter int P_CNT_W = 16
) (
    input  logic               CLK160M,
    input  logic               RESET,
    input  logic               clr,
    input  logic               en,
    output logic [P_CNT_W-1:0] cnt
);

    always_ff @(posedge CLK160M) begin
        if (RESET || clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + P_CNT_W'(1);
        end
    end

endmodule

// File: rtl/ptmch_trg_seq.sv
// Two-stage trigger sequencer: a stage-0 edge, then an optional stage-1 edge inside a window.
// A completed sequence emits one capture pulse and updates the fire/timeout statistics.
//
//   state   | meaning
//   S_IDLE  | disarmed, waiting for ARM
//   S_WAIT0 | armed, waiting for a stage-0 edge
//   S_WAIT1 | stage 0 seen, waiting for a stage-1 edge inside the window
//   S_FIRE  | CAP_PLS high for P_PLS_WIDTH cycles
//   S_HOLD  | dead time after the capture pulse
module ptmch_trg_seq
    import ptmch_pkg::*;
#(
    parameter int P_NUM_TRG   = 5,
    parameter int P_CNT_W     = 16,
    parameter int P_PLS_WIDTH = 16
) (
    input  logic                 CLK160M,
    input  logic                 RESET,
    input  logic [P_NUM_TRG-1:0] TRG_PLS,
    input  logic                 ARM,
    input  logic                 DISARM,
    input  logic                 MODE_CONT,
    input  logic [P_NUM_TRG-1:0] STG0_SEL,
    input  logic [P_NUM_TRG-1:0] STG1_SEL,
    input  logic [P_CNT_W-1:0]   WINDOW,
    input  logic [P_CNT_W-1:0]   HOLDOFF,
    output logic                 CAP_PLS,
    output logic [P_NUM_TRG-1:0] CAP_SRC,
    output logic                 ARMED,
    output logic                 BUSY,
    output logic [P_CNT_W-1:0]   FIRE_CNT,
    output logic [P_CNT_W-1:0]   TMO_CNT
);

    localparam int PLS_W = $clog2(P_PLS_WIDTH + 1);
    localparam logic [PLS_W-1:0] PLS_LOAD = PLS_W'(P_PLS_WIDTH - 1);

    t_seq_state state;
    t_seq_state state_nxt;

    logic [P_NUM_TRG-1:0] trg_q;
    logic [P_NUM_TRG-1:0] trg_edge;
    logic [P_NUM_TRG-1:0] stg0_hit;
    logic [P_NUM_TRG-1:0] stg1_hit;
    logic [P_NUM_TRG-1:0] fire_src;
    logic [P_NUM_TRG-1:0] cfg_stg0;
    logic [P_NUM_TRG-1:0] cfg_stg1;
    logic [P_CNT_W-1:0]   cfg_window;
    logic [P_CNT_W-1:0]   cfg_holdoff;
    logic                 cfg_cont;
    logic [P_NUM_TRG-1:0] cap_src_q;
    logic [PLS_W-1:0]     pls_cnt;
    logic [P_CNT_W-1:0]   win_cnt;
    logic [P_CNT_W-1:0]   hold_cnt;
    logic                 arm_acc;
    logic                 fire_evt;
    logic                 tmo_evt;

    assign trg_edge = TRG_PLS & ~trg_q;
    assign stg0_hit = trg_edge & cfg_stg0;
    assign stg1_hit = trg_edge & cfg_stg1;

    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stage 0 is searched first, so a stage-1 edge in the same cycle is never taken.
    always_comb begin
        state_nxt = state;
        arm_acc   = 1'b0;
        fire_evt  = 1'b0;
        fire_src  = '0;
        tmo_evt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (ARM && (STG0_SEL != '0)) begin
                    arm_acc   = 1'b1;
                    state_nxt = S_WAIT0;
                end
            end
            S_WAIT0: begin
                if (stg0_hit != '0) begin
                    if (cfg_stg1 == '0) begin
                        fire_evt  = 1'b1;
                        fire_src  = stg0_hit;
                        state_nxt = S_FIRE;
                    end else begin
                        state_nxt = S_WAIT1;
                    end
                end
            end
            S_WAIT1: begin
                if (stg1_hit != '0) begin
                    fire_evt  = 1'b1;
                    fire_src  = stg1_hit;
                    state_nxt = S_FIRE;
                end else if ((cfg_window != '0) && (win_cnt == cfg_window - P_CNT_W'(1))) begin
                    tmo_evt   = 1'b1;
                    state_nxt = S_WAIT0;
                end
            end
            S_FIRE: begin
                if (pls_cnt == '0) begin
                    if (cfg_holdoff != '0) begin
                        state_nxt = S_HOLD;
                    end else begin
                        state_nxt = cfg_cont ? S_WAIT0 : S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                if (hold_cnt == cfg_holdoff - P_CNT_W'(1)) begin
                    state_nxt = cfg_cont ? S_WAIT0 : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (DISARM) begin
            state_nxt = S_IDLE;
            arm_acc   = 1'b0;
            fire_evt  = 1'b0;
            tmo_evt   = 1'b0;
        end
    end

    always_comb begin
        CAP_PLS = (state == S_FIRE);
        ARMED   = (state == S_WAIT0) || (state == S_WAIT1);
        BUSY    = (state != S_IDLE);
        CAP_SRC = cap_src_q;
    end

    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            trg_q       <= '0;
            cfg_stg0    <= '0;
            cfg_stg1    <= '0;
            cfg_window  <= '0;
            cfg_holdoff <= '0;
            cfg_cont    <= 1'b0;
            cap_src_q   <= '0;
            pls_cnt     <= PLS_LOAD;
        end else begin
            trg_q <= TRG_PLS;
            if (arm_acc) begin
                cfg_stg0    <= STG0_SEL;
                cfg_stg1    <= STG1_SEL;
                cfg_window  <= WINDOW;
                cfg_holdoff <= HOLDOFF;
                cfg_cont    <= MODE_CONT;
            end
            if (fire_evt) begin
                cap_src_q <= fire_src;
            end
            // Pulse timer reloads outside S_FIRE and runs down to terminal count inside it.
            if (state != S_FIRE) begin
                pls_cnt <= PLS_LOAD;
            end else if (pls_cnt != '0) begin
                pls_cnt <= pls_cnt - PLS_W'(1);
            end
        end
    end

    ptmch_sat_cnt #(.P_CNT_W(P_CNT_W)) u_fire_cnt (
        .CLK160M (CLK160M),
        .RESET   (RESET),
        .clr     (1'b0),
        .en      (fire_evt),
        .cnt     (FIRE_CNT)
    );

    ptmch_sat_cnt #(.P_CNT_W(P_CNT_W)) u_tmo_cnt (
        .CLK160M (CLK160M),
        .RESET   (RESET),
        .clr     (1'b0),
        .en      (tmo_evt),
        .cnt     (TMO_CNT)
    );

    ptmch_sat_cnt #(.P_CNT_W(P_CNT_W)) u_win_cnt (
        .CLK160M (CLK160M),
        .RESET   (RESET),
        .clr     (state != S_WAIT1),
        .en      (state == S_WAIT1),
        .cnt     (win_cnt)
    );

    ptmch_sat_cnt #(.P_CNT_W(P_CNT_W)) u_hold_cnt (
        .CLK160M (CLK160M),
        .RESET   (RESET),
        .clr     (state != S_HOLD),
        .en      (state == S_HOLD),
        .cnt     (hold_cnt)
    );

endmodule

// File: tb/tb_ptmch_trg_seq.sv
// Bench for ptmch_trg_seq: reset, a per-cycle vector table, directed multi-cycle sequences
// and randomized trigger traffic checked against an event-search model of the sequencer.
module tb_ptmch_trg_seq;
    import ptmch_pkg::*;

    localparam int PW = 16;

    logic        CLK160M;
    logic        RESET;
    logic [4:0]  TRG_PLS;
    logic        ARM;
    logic        DISARM;
    logic        MODE_CONT;
    logic [4:0]  STG0_SEL;
    logic [4:0]  STG1_SEL;
    logic [15:0] WINDOW;
    logic [15:0] HOLDOFF;
    logic        CAP_PLS;
    logic [4:0]  CAP_SRC;
    logic        ARMED;
    logic        BUSY;
    logic [15:0] FIRE_CNT;
    logic [15:0] TMO_CNT;
    logic        s_cap;
    logic [4:0]  s_src;
    logic        s_armed;
    logic        s_busy;
    logic [3:0]  s_fire;
    logic [3:0]  s_tmo;

    ptmch_trg_seq dut (
        .CLK160M (CLK160M), .RESET (RESET), .TRG_PLS (TRG_PLS), .ARM (ARM), .DISARM (DISARM),
        .MODE_CONT (MODE_CONT), .STG0_SEL (STG0_SEL), .STG1_SEL (STG1_SEL), .WINDOW (WINDOW),
        .HOLDOFF (HOLDOFF), .CAP_PLS (CAP_PLS), .CAP_SRC (CAP_SRC), .ARMED (ARMED), .BUSY (BUSY),
        .FIRE_CNT (FIRE_CNT), .TMO_CNT (TMO_CNT)
    );

    ptmch_trg_seq #(.P_CNT_W(4)) dut_s (
        .CLK160M (CLK160M), .RESET (RESET), .TRG_PLS (TRG_PLS), .ARM (ARM), .DISARM (DISARM),
        .MODE_CONT (MODE_CONT), .STG0_SEL (STG0_SEL), .STG1_SEL (STG1_SEL), .WINDOW (WINDOW[3:0]),
        .HOLDOFF (HOLDOFF[3:0]), .CAP_PLS (s_cap), .CAP_SRC (s_src), .ARMED (s_armed), .BUSY (s_busy),
        .FIRE_CNT (s_fire), .TMO_CNT (s_tmo)
    );

    initial CLK160M = 1'b0;
    always #5 CLK160M = ~CLK160M;

    typedef struct packed {
        logic       arm;
        logic       dis;
        logic [4:0] g0;
        logic [4:0] trg;
        logic       cap;
        logic       armed;
        logic       busy;
        logic [15:0] fire;
        logic [4:0] src;
    } vec_t;

    int         n_chk = 0;
    int         n_err = 0;
    int         exp_fire = 0;
    int         exp_tmo = 0;
    logic [4:0] exp_src = '0;
    logic [4:0] sched [0:1023];
    bit         cap_log [0:1023];
    bit         armed_log [0:1023];
    bit         busy_log [0:1023];
    logic [3:0] sfire_log [0:1023];
    vec_t       tbl [0:13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK160M);
        #1;
    endtask

    function automatic vec_t mkv(logic arm, logic dis, logic [4:0] g0, logic [4:0] trg, logic cap,
                                 logic armed, logic busy, logic [15:0] fire, logic [4:0] src);
        vec_t v;
        v.arm = arm; v.dis = dis; v.g0 = g0; v.trg = trg; v.cap = cap;
        v.armed = armed; v.busy = busy; v.fire = fire; v.src = src;
        return v;
    endfunction

    task automatic sched_clr();
        for (int j = 0; j < 1024; j++) sched[j] = '0;
    endtask

    task automatic pulse(input int b, input int start);
        for (int j = start; j < start + 15; j++) sched[j][b] = 1'b1;
    endtask

    task automatic sched_rand(input int n);
        int hi [5];
        int gap [5];
        sched_clr();
        for (int b = 0; b < 5; b++) begin
            hi[b] = 0;
            gap[b] = int'($urandom_range(0, 20));
        end
        for (int j = 1; j < n; j++) begin
            for (int b = 0; b < 5; b++) begin
                if (hi[b] > 0) begin
                    sched[j][b] = 1'b1;
                    hi[b]--;
                end else if (gap[b] > 0) begin
                    gap[b]--;
                end else if ($urandom_range(0, 19) == 0) begin
                    sched[j][b] = 1'b1;
                    hi[b] = 14;
                    gap[b] = int'($urandom_range(1, 30));
                end
            end
        end
    endtask

    // ARM at cycle 0 with the current config, play sched for n cycles, then disarm.
    // Expected behaviour comes from searching the edge list for qualifying events.
    task automatic play(input int n, input string nm);
        logic [4:0] e [0:1023];
        bit         ecap [0:1023];
        logic [4:0] g0, g1, s, prev;
        int         w, h, t, c, f, lim, fires, tmos;
        bit         cont;
        g0 = STG0_SEL; g1 = STG1_SEL; w = int'(WINDOW); h = int'(HOLDOFF); cont = MODE_CONT;
        prev = '0;
        for (int j = 0; j < n; j++) begin
            e[j] = sched[j] & ~prev;
            prev = sched[j];
            ecap[j] = 1'b0;
        end
        fires = 0; tmos = 0; t = 1; s = '0;
        while (1) begin
            c = -1;
            for (int i = t; i < n; i++) if ((e[i] & g0) != '0) begin c = i; break; end
            if (c < 0) break;
            f = -1;
            if (g1 == '0) begin
                f = c; s = e[c] & g0;
            end else begin
                lim = (w == 0) ? n - 1 : ((c + w < n - 1) ? c + w : n - 1);
                for (int i = c + 1; i <= lim; i++) if ((e[i] & g1) != '0) begin f = i; s = e[i] & g1; break; end
                if (f < 0) begin
                    if (w == 0 || c + w > n - 1) break;
                    tmos++;
                    t = c + w + 1;
                    continue;
                end
            end
            fires++;
            exp_src = s;
            for (int j = f; j < f + PW && j < n; j++) ecap[j] = 1'b1;
            if (!cont) break;
            t = f + PW + 1 + h;
        end
        exp_fire = (exp_fire + fires > 65535) ? 65535 : exp_fire + fires;
        exp_tmo  = (exp_tmo + tmos > 65535) ? 65535 : exp_tmo + tmos;

        TRG_PLS = '0; ARM = 1'b0; DISARM = 1'b1;
        cyc();
        DISARM = 1'b0;
        for (int i = 0; i < n; i++) begin
            TRG_PLS = sched[i];
            ARM = (i == 0);
            cyc();
            cap_log[i] = CAP_PLS;
            armed_log[i] = ARMED;
            busy_log[i] = BUSY;
            sfire_log[i] = s_fire;
            chk({nm, " cap"}, 32'(CAP_PLS), 32'(ecap[i]));
        end
        ARM = 1'b0; TRG_PLS = '0; DISARM = 1'b1;
        cyc();
        DISARM = 1'b0;
        chk({nm, " fire_cnt"}, 32'(FIRE_CNT), 32'(exp_fire));
        chk({nm, " tmo_cnt"}, 32'(TMO_CNT), 32'(exp_tmo));
        chk({nm, " cap_src"}, 32'(CAP_SRC), 32'(exp_src));
    endtask

    task automatic set_cfg(input logic [4:0] g0, input logic [4:0] g1, input int w, input int h,
                           input logic cont);
        STG0_SEL = g0; STG1_SEL = g1; WINDOW = 16'(w); HOLDOFF = 16'(h); MODE_CONT = cont;
    endtask

    initial begin
        int fb;
        RESET = 1'b1; TRG_PLS = '0; ARM = 1'b0; DISARM = 1'b0;
        set_cfg(5'b00100, 5'b0, 0, 0, 1'b0);
        cyc(); cyc();
        chk("rst cap", 32'(CAP_PLS), 0);
        chk("rst src", 32'(CAP_SRC), 0);
        chk("rst armed", 32'(ARMED), 0);
        chk("rst busy", 32'(BUSY), 0);
        chk("rst fire", 32'(FIRE_CNT), 0);
        chk("rst tmo", 32'(TMO_CNT), 0);
        chk("rst s_state", 32'({s_cap, s_armed, s_busy, s_src}), 0);
        chk("rst s_cnt", 32'({s_fire, s_tmo}), 0);

        // Per-cycle table: ignored ARMs, config latching, single-stage fire, DISARM truncation.
        tbl[0]  = mkv(1, 1, 5'b00100, 5'b00000, 0, 0, 0, 0, 5'b00000);
        tbl[1]  = mkv(1, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 5'b00000);
        tbl[2]  = mkv(1, 0, 5'b00100, 5'b00000, 0, 1, 1, 0, 5'b00000);
        tbl[3]  = mkv(0, 0, 5'b11111, 5'b00001, 0, 1, 1, 0, 5'b00000);
        tbl[4]  = mkv(0, 0, 5'b11111, 5'b00100, 1, 0, 1, 1, 5'b00100);
        tbl[5]  = mkv(0, 0, 5'b11111, 5'b00100, 1, 0, 1, 1, 5'b00100);
        tbl[6]  = mkv(0, 0, 5'b11111, 5'b00100, 1, 0, 1, 1, 5'b00100);
        tbl[7]  = mkv(0, 0, 5'b11111, 5'b00100, 1, 0, 1, 1, 5'b00100);
        tbl[8]  = mkv(0, 0, 5'b11111, 5'b00100, 1, 0, 1, 1, 5'b00100);
        tbl[9]  = mkv(0, 1, 5'b00100, 5'b00100, 0, 0, 0, 1, 5'b00100);
        tbl[10] = mkv(0, 0, 5'b00100, 5'b00000, 0, 0, 0, 1, 5'b00100);
        tbl[11] = mkv(1, 0, 5'b00100, 5'b00100, 0, 1, 1, 1, 5'b00100);
        tbl[12] = mkv(0, 0, 5'b00100, 5'b00100, 0, 1, 1, 1, 5'b00100);
        tbl[13] = mkv(1, 1, 5'b00100, 5'b00000, 0, 0, 0, 1, 5'b00100);
        RESET = 1'b0;
        for (int r = 0; r < 14; r++) begin
            ARM = tbl[r].arm; DISARM = tbl[r].dis; STG0_SEL = tbl[r].g0; TRG_PLS = tbl[r].trg;
            cyc();
            chk($sformatf("tbl%0d cap", r), 32'(CAP_PLS), 32'(tbl[r].cap));
            chk($sformatf("tbl%0d armed", r), 32'(ARMED), 32'(tbl[r].armed));
            chk($sformatf("tbl%0d busy", r), 32'(BUSY), 32'(tbl[r].busy));
            chk($sformatf("tbl%0d fire", r), 32'(FIRE_CNT), 32'(tbl[r].fire));
            chk($sformatf("tbl%0d src", r), 32'(CAP_SRC), 32'(tbl[r].src));
        end
        ARM = 1'b0; DISARM = 1'b0; TRG_PLS = '0;
        exp_fire = 1; exp_src = 5'b00100;

        // Two-stage hit on the last window cycle.
        set_cfg(5'(1 << TRG_PAGE_READ), 5'(1 << TRG_PGM_EXEC), 100, 0, 1'b0);
        sched_clr(); pulse(TRG_PAGE_READ, 1); pulse(TRG_PGM_EXEC, 101);
        fb = exp_fire;
        play(150, "win_hit");
        chk("win_hit cap100", 32'(cap_log[100]), 0);
        chk("win_hit cap101", 32'(cap_log[101]), 1);
        chk("win_hit cap116", 32'(cap_log[116]), 1);
        chk("win_hit cap117", 32'(cap_log[117]), 0);
        chk("win_hit idle", 32'(busy_log[149]), 0);
        chk("win_hit src", 32'(CAP_SRC), 32'h01);
        chk("win_hit fires", 32'(FIRE_CNT), 32'(fb + 1));

        // One cycle late: timeout, still armed.
        sched_clr(); pulse(TRG_PAGE_READ, 1); pulse(TRG_PGM_EXEC, 102);
        play(150, "win_miss");
        chk("win_miss armed101", 32'(armed_log[101]), 1);
        chk("win_miss cap102", 32'(cap_log[102]), 0);
        chk("win_miss armed149", 32'(armed_log[149]), 1);
        chk("win_miss tmo", 32'(TMO_CNT), 1);

        // Same bit in both stages: first edge is stage 0 only.
        set_cfg(5'(1 << TRG_RD_STAT), 5'(1 << TRG_RD_STAT), 0, 0, 1'b0);
        sched_clr(); pulse(TRG_RD_STAT, 1); pulse(TRG_RD_STAT, 21);
        play(60, "same_bit");
        chk("same_bit cap2", 32'(cap_log[2]), 0);
        chk("same_bit cap20", 32'(cap_log[20]), 0);
        chk("same_bit cap21", 32'(cap_log[21]), 1);
        chk("same_bit src", 32'(CAP_SRC), 32'h02);

        // Continuous mode with holdoff: edges during fire+holdoff are dropped.
        set_cfg(5'(1 << TRG_WR_STAT), 5'b0, 0, 50, 1'b1);
        sched_clr();
        for (int m = 0; m < 10; m++) pulse(TRG_WR_STAT, 1 + 30 * m);
        fb = exp_fire;
        play(300, "cont");
        chk("cont cap31", 32'(cap_log[31]), 0);
        chk("cont cap61", 32'(cap_log[61]), 0);
        chk("cont cap91", 32'(cap_log[91]), 1);
        chk("cont fires", 32'(FIRE_CNT), 32'(fb + 4));

        // Randomized configurations and trigger traffic.
        for (int it = 0; it < 10; it++) begin
            set_cfg(5'($urandom_range(1, 31)),
                    ($urandom_range(0, 2) == 0) ? 5'b0 : 5'($urandom_range(1, 31)),
                    ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 60)),
                    ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 40)),
                    1'($urandom_range(0, 1)));
            sched_rand(500);
            play(500, $sformatf("rnd%0d", it));
        end

        // Saturation on the 4-bit build: 17 fires after a reset.
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        exp_fire = 0; exp_tmo = 0; exp_src = '0;
        chk("sat start", 32'(s_fire), 0);
        set_cfg(5'(1 << TRG_PGM_EXEC), 5'b0, 0, 0, 1'b1);
        sched_clr();
        for (int m = 0; m < 17; m++) pulse(TRG_PGM_EXEC, 1 + 20 * m);
        play(345, "sat");
        chk("sat fire14", 32'(sfire_log[261]), 32'hE);
        chk("sat fire15", 32'(sfire_log[281]), 32'hF);
        chk("sat fire16", 32'(sfire_log[301]), 32'hF);
        chk("sat final", 32'(s_fire), 32'hF);
        chk("sat wide", 32'(FIRE_CNT), 17);

        // Reset asserted while waiting for stage 1.
        set_cfg(5'(1 << TRG_PGM_EXEC), 5'(1 << TRG_RD_STAT), 0, 0, 1'b0);
        ARM = 1'b1;
        cyc();
        ARM = 1'b0; TRG_PLS = 5'b00001;
        cyc();
        chk("mid armed", 32'(ARMED), 1);
        chk("mid busy", 32'(BUSY), 1);
        RESET = 1'b1;
        cyc();
        chk("mid rst state", 32'({CAP_PLS, ARMED, BUSY, CAP_SRC}), 0);
        chk("mid rst cnt", 32'({FIRE_CNT, TMO_CNT}), 0);
        chk("mid rst s", 32'({s_cap, s_armed, s_busy, s_src, s_fire, s_tmo}), 0);
        RESET = 1'b0; TRG_PLS = '0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
